// File: rtl/nmr_bstrm_simp_ctrl.sv
// nmr_bstrm_simp_ctrl: fetches packed pulse words from bitstream RAM and sequences them into the simple datapath
module nmr_bstrm_simp_ctrl #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 10,
  parameter int END_PAD    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  seq_start_i,
  input  logic                  abort_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_rd_o,
  input  logic [DATA_WIDTH+5:0] mem_q_i,
  output logic                  start_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  pls_pol_o,
  output logic [3:0]            mux_sel_o,
  input  logic                  dpath_rdy_i,
  output logic                  dpath_rst_o,
  output logic                  busy_o,
  output logic                  done_o
);
  typedef enum logic [2:0] {S_IDLE, S_RD0, S_LD0, S_PF, S_WAIT, S_ISSUE, S_TAIL} state_e;
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rd_q, rd_d, start_q, start_d, done_q, done_d, drst_q, drst_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  pol_q, pol_d, last_q, last_d, rdy_q, rdy_d;
  logic [3:0]            mux_q, mux_d;
  logic [DATA_WIDTH+5:0] wbuf_q, wbuf_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      drst_q  <= 1'b1;
      data_q  <= '0;
      pol_q   <= 1'b0;
      mux_q   <= '0;
      last_q  <= 1'b0;
      rdy_q   <= 1'b0;
      wbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      start_q <= start_d;
      done_q  <= done_d;
      drst_q  <= drst_d;
      data_q  <= data_d;
      pol_q   <= pol_d;
      mux_q   <= mux_d;
      last_q  <= last_d;
      rdy_q   <= rdy_d;
      wbuf_q  <= wbuf_d;
    end
  // Reads are launched on the edge entering RD0/LD0/ISSUE so each word is valid on the following cycle
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rd_d    = 1'b0;
    start_d = 1'b0;
    done_d  = 1'b0;
    drst_d  = drst_q;
    data_d  = data_q;
    pol_d   = pol_q;
    mux_d   = mux_q;
    last_d  = last_q;
    wbuf_d  = wbuf_q;
    rdy_d   = rdy_q | dpath_rdy_i;
    case (state_q)
      S_IDLE: if (seq_start_i) begin
        state_d = S_RD0;
        addr_d  = '0;
        rd_d    = 1'b1;
      end
      S_RD0: begin
        state_d = S_LD0;
        addr_d  = addr_q + 1'b1;
        rd_d    = 1'b1;
      end
      S_LD0: begin
        {last_d, pol_d, mux_d, data_d} = mem_q_i;
        drst_d  = 1'b0;
        state_d = S_PF;
      end
      S_PF: begin
        wbuf_d  = mem_q_i;
        state_d = S_WAIT;
      end
      S_WAIT: if (rdy_q) begin
        rdy_d = dpath_rdy_i;
        if (last_q) begin
          data_d  = DATA_WIDTH'(END_PAD);
          pol_d   = 1'b0;
          mux_d   = '0;
          start_d = 1'b1;
          state_d = S_TAIL;
        end else begin
          addr_d  = addr_q + 1'b1;
          rd_d    = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        {last_d, pol_d, mux_d, data_d} = wbuf_q;
        start_d = 1'b1;
        state_d = S_PF;
      end
      S_TAIL: if (rdy_q) begin
        rdy_d   = dpath_rdy_i;
        done_d  = 1'b1;
        drst_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_i) begin
      state_d = S_IDLE;
      addr_d  = '0;
      rd_d    = 1'b0;
      start_d = 1'b0;
      done_d  = 1'b0;
      drst_d  = 1'b1;
      data_d  = '0;
      pol_d   = 1'b0;
      mux_d   = '0;
      last_d  = 1'b0;
      wbuf_d  = '0;
      rdy_d   = 1'b0;
    end
  end
  assign mem_addr_o  = addr_q;
  assign mem_rd_o    = rd_q;
  assign start_o     = start_q;
  assign done_o      = done_q;
  assign dpath_rst_o = drst_q;
  assign data_o      = data_q;
  assign pls_pol_o   = pol_q;
  assign mux_sel_o   = mux_q;
  assign busy_o      = state_q != S_IDLE;
endmodule

// File: tb/tb_nmr_bstrm_simp_ctrl.sv
// tb_nmr_bstrm_simp_ctrl: per-cycle vector tables with hand-derived expected outputs, RAM modelled in the bench
module tb_nmr_bstrm_simp_ctrl;
  localparam int DW = 24;
  logic clk = 1'b0, rst_n = 1'b0;
  logic seq_start = 1'b0, abort = 1'b0, rdy = 1'b0;
  logic [1:0] mem_addr;
  logic mem_rd, start, pol, dpath_rst, busy, done;
  logic [DW+5:0] mem_q = '0;
  logic [DW-1:0] data;
  logic [3:0] mux;
  logic [DW+5:0] ram [4];
  int n_vec = 0, n_err = 0;

  typedef struct {
    bit ss, ab, rdy;
    int addr;
    bit rd, st;
    int d;
    bit pol;
    int mux;
    bit drst, busy, done;
  } vec_t;
  vec_t tbl[$];

  nmr_bstrm_simp_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(2), .END_PAD(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .seq_start_i(seq_start), .abort_i(abort),
    .mem_addr_o(mem_addr), .mem_rd_o(mem_rd), .mem_q_i(mem_q),
    .start_o(start), .data_o(data), .pls_pol_o(pol), .mux_sel_o(mux),
    .dpath_rdy_i(rdy), .dpath_rst_o(dpath_rst), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_rd) mem_q <= ram[mem_addr];

  function automatic logic [DW+5:0] w(input bit last, input bit p, input int m, input int d);
    return {last, p, 4'(m), 24'(d)};
  endfunction

  function automatic logic [35:0] exp_of(input vec_t v);
    return {2'(v.addr), v.rd, v.st, 24'(v.d), v.pol, 4'(v.mux), v.drst, v.busy, v.done};
  endfunction

  function automatic logic [35:0] act();
    return {mem_addr, mem_rd, start, data, pol, mux, dpath_rst, busy, done};
  endfunction

  task automatic cmp(input string name, input int idx, input logic [35:0] got, input logic [35:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s #%0d: got addr/rd/st/data/pol/mux/rst/busy/done=%h want %h", name, idx, got, want);
    end
  endtask

  task automatic add(input bit ss, ab, r, input int a, input bit rd, st, input int d,
                     input bit p, input int m, input bit dr, bs, dn);
    vec_t v;
    v.ss = ss; v.ab = ab; v.rdy = r; v.addr = a; v.rd = rd; v.st = st;
    v.d = d; v.pol = p; v.mux = m; v.drst = dr; v.busy = bs; v.done = dn;
    tbl.push_back(v);
  endtask

  task automatic run(input string name);
    foreach (tbl[i]) begin
      @(negedge clk);
      seq_start = tbl[i].ss; abort = tbl[i].ab; rdy = tbl[i].rdy;
      @(posedge clk);
      #1 cmp(name, i, act(), exp_of(tbl[i]));
    end
    tbl.delete();
  endtask

  task automatic load_main();
    ram[0] = w(0, 1, 0, 10); ram[1] = w(0, 0, 0, 20); ram[2] = w(1, 1, 3, 6); ram[3] = '0;
  endtask

  task automatic single_to_tail(input int a0);
    add(1,0,0, 0,1,0, a0==1 ? 8 : 0,0,0, 1,1,0);
    add(0,0,0, 1,1,0, a0==1 ? 8 : 0,0,0, 1,1,0);
    add(0,0,0, 1,0,0, 4,1,5, 0,1,0);
    add(0,0,0, 1,0,0, 4,1,5, 0,1,0);
    add(0,0,1, 1,0,0, 4,1,5, 0,1,0);
    add(0,0,0, 1,0,1, 8,0,0, 0,1,0);
  endtask

  localparam logic [35:0] RST_VAL = {2'd0, 1'b0, 1'b0, 24'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0};

  initial begin
    load_main();
    #12 cmp("reset", 0, act(), RST_VAL);
    @(negedge clk) rst_n = 1'b1;

    // three-word sequence; SEQ_START during PF must be ignored
    add(1,0,0, 0,1,0, 0,0,0, 1,1,0);
    add(0,0,0, 1,1,0, 0,0,0, 1,1,0);
    add(0,0,0, 1,0,0, 10,1,0, 0,1,0);
    add(0,0,0, 1,0,0, 10,1,0, 0,1,0);
    add(0,0,1, 1,0,0, 10,1,0, 0,1,0);
    add(0,0,0, 2,1,0, 10,1,0, 0,1,0);
    add(0,0,0, 2,0,1, 20,0,0, 0,1,0);
    add(1,0,0, 2,0,0, 20,0,0, 0,1,0);
    add(0,0,1, 2,0,0, 20,0,0, 0,1,0);
    add(0,0,0, 3,1,0, 20,0,0, 0,1,0);
    add(0,0,0, 3,0,1, 6,1,3, 0,1,0);
    add(0,0,0, 3,0,0, 6,1,3, 0,1,0);
    add(0,0,1, 3,0,0, 6,1,3, 0,1,0);
    add(0,0,0, 3,0,1, 8,0,0, 0,1,0);
    add(0,0,1, 3,0,0, 8,0,0, 0,1,0);
    add(0,0,0, 3,0,0, 8,0,0, 1,0,1);
    add(0,0,0, 3,0,0, 8,0,0, 1,0,0);
    run("main");

    // RDY while in PF, short pulses; RDY coinciding with WAIT consume stays pending for TAIL
    ram[0] = w(0, 0, 1, 3); ram[1] = w(0, 1, 2, 3); ram[2] = w(1, 0, 4, 3);
    add(1,0,0, 0,1,0, 8,0,0, 1,1,0);
    add(0,0,0, 1,1,0, 8,0,0, 1,1,0);
    add(0,0,0, 1,0,0, 3,0,1, 0,1,0);
    add(0,0,1, 1,0,0, 3,0,1, 0,1,0);
    add(0,0,0, 2,1,0, 3,0,1, 0,1,0);
    add(0,0,0, 2,0,1, 3,1,2, 0,1,0);
    add(0,0,1, 2,0,0, 3,1,2, 0,1,0);
    add(0,0,0, 3,1,0, 3,1,2, 0,1,0);
    add(0,0,0, 3,0,1, 3,0,4, 0,1,0);
    add(0,0,1, 3,0,0, 3,0,4, 0,1,0);
    add(0,0,1, 3,0,1, 8,0,0, 0,1,0);
    add(0,0,0, 3,0,0, 8,0,0, 1,0,1);
    add(0,0,0, 3,0,0, 8,0,0, 1,0,0);
    run("pf_rdy");

    // abort at word 2 clears pending RDY, beats SEQ_START, then restart from address 0
    load_main();
    add(1,0,0, 0,1,0, 8,0,0, 1,1,0);
    add(0,0,0, 1,1,0, 8,0,0, 1,1,0);
    add(0,0,0, 1,0,0, 10,1,0, 0,1,0);
    add(0,0,0, 1,0,0, 10,1,0, 0,1,0);
    add(0,0,1, 1,0,0, 10,1,0, 0,1,0);
    add(0,0,0, 2,1,0, 10,1,0, 0,1,0);
    add(0,0,0, 2,0,1, 20,0,0, 0,1,0);
    add(0,1,1, 0,0,0, 0,0,0, 1,0,0);
    add(1,1,0, 0,0,0, 0,0,0, 1,0,0);
    add(1,0,0, 0,1,0, 0,0,0, 1,1,0);
    add(0,0,0, 1,1,0, 0,0,0, 1,1,0);
    add(0,0,0, 1,0,0, 10,1,0, 0,1,0);
    add(0,0,0, 1,0,0, 10,1,0, 0,1,0);
    add(0,0,0, 1,0,0, 10,1,0, 0,1,0);
    add(0,1,0, 0,0,0, 0,0,0, 1,0,0);
    run("abort");

    // single LAST word: no START for word 0, one for the blank, then DONE
    ram[0] = w(1, 1, 5, 4);
    single_to_tail(0);
    add(0,0,1, 1,0,0, 8,0,0, 0,1,0);
    add(0,0,0, 1,0,0, 8,0,0, 1,0,1);
    add(0,0,0, 1,0,0, 8,0,0, 1,0,0);
    run("single");

    // asynchronous reset while in TAIL
    single_to_tail(1);
    run("pre_rst");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 cmp("async_rst", 0, act(), RST_VAL);
    @(negedge clk) rst_n = 1'b1;

    // no LAST word: address wraps 1,2,3,0,1,... and issuing continues
    for (int i = 0; i < 4; i++) ram[i] = w(0, i[0], i, 10 + i);
    add(1,0,0, 0,1,0, 0,0,0, 1,1,0);
    add(0,0,0, 1,1,0, 0,0,0, 1,1,0);
    add(0,0,0, 1,0,0, 10,0,0, 0,1,0);
    add(0,0,0, 1,0,0, 10,0,0, 0,1,0);
    for (int k = 0; k < 6; k++) begin
      int j, p;
      j = (1 + k) % 4;
      p = k % 4;
      add(0,0,1, j,0,0, 10+p,p[0],p, 0,1,0);
      add(0,0,0, (j+1)%4,1,0, 10+p,p[0],p, 0,1,0);
      add(0,0,0, (j+1)%4,0,1, 10+j,j[0],j, 0,1,0);
      add(0,0,0, (j+1)%4,0,0, 10+j,j[0],j, 0,1,0);
    end
    add(0,1,0, 0,0,0, 0,0,0, 1,0,0);
    run("wrap");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
